glitch_sequencer: RTL and testbench

Control stage directly upstream of the clock-glitch mux. It arms on command, waits for an external trigger, counts a programmable delay, then drives `glitch_en`/`glitch_mode` for a programmable width, optionally repeating with a programmable gap. Its outputs connect straight to the mux's `en` and `mode` inputs, so every glitch is cycle-accurate relative to the synchronized trigger.

---
 rtl/glitch_sequencer_if.sv | 37 +++
 rtl/glitch_sequencer.sv | 176 +++++++++++++++++
 tb/tb_glitch_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/glitch_sequencer_if.sv
// ---------------------------------------------------------------------------
// glitch_sequencer_if : control/config/status bundle for glitch_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface glitch_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
);
  logic             arm;
  logic             abort;
  logic             trigger;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [REP_W-1:0] cfg_repeat;
  logic [7:0]       cfg_mode;
  logic             glitch_en;
  logic [7:0]       glitch_mode;
  logic             armed;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pulse_cnt;

  modport master (
    output arm, abort, trigger, cfg_delay, cfg_width, cfg_gap, cfg_repeat, cfg_mode,
    input  glitch_en, glitch_mode, armed, busy, done, pulse_cnt
  );

  modport slave (
    input  arm, abort, trigger, cfg_delay, cfg_width, cfg_gap, cfg_repeat, cfg_mode,
    output glitch_en, glitch_mode, armed, busy, done, pulse_cnt
  );
endinterface

`default_nettype wire

// File: rtl/glitch_sequencer.sv
// ---------------------------------------------------------------------------
// glitch_sequencer : arm / trigger / delay / pulse / gap sequencer driving the
//                    clock-glitch mux en and mode inputs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module glitch_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  wire logic           clk_in,
  input  wire logic           rst_n,
  glitch_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [REP_W-1:0] REP_MAX = {REP_W{1'b1}};

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [REP_W-1:0] pulse_cnt_q, pulse_cnt_nx;
  logic             latch_cfg;
  logic             done_nx;
  logic             enter_pulse;

  logic [CNT_W-1:0] delay_q, width_q, gap_q;
  logic [REP_W-1:0] repeat_q;
  logic [7:0]       mode_q;

  logic             sync1, sync2, sync3;
  logic             trig_evt;

  logic             glitch_en_q;
  logic [7:0]       glitch_mode_q;
  logic             armed_q, busy_q, done_q;

  // Stages 1-2 resolve metastability; stage 3 only serves edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.trigger;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign trig_evt = sync2 & ~sync3;

  // Zero width/gap/repeat are folded to 1 here so the FSM never sees them.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      delay_q  <= '0;
      width_q  <= CNT_ONE;
      gap_q    <= CNT_ONE;
      repeat_q <= REP_ONE;
      mode_q   <= 8'h00;
    end else if (latch_cfg) begin
      delay_q  <= bus.cfg_delay;
      width_q  <= (bus.cfg_width == '0) ? CNT_ONE : bus.cfg_width;
      gap_q    <= (bus.cfg_gap == '0) ? CNT_ONE : bus.cfg_gap;
      repeat_q <= (bus.cfg_repeat == '0) ? REP_ONE : bus.cfg_repeat;
      mode_q   <= bus.cfg_mode;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pulse_cnt_nx = pulse_cnt_q;
    latch_cfg    = 1'b0;
    done_nx      = 1'b0;
    enter_pulse  = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.arm) begin
          state_nx     = S_ARMED;
          latch_cfg    = 1'b1;
          pulse_cnt_nx = '0;
        end
      end
      S_ARMED: begin
        if (trig_evt) begin
          if (delay_q == '0) begin
            enter_pulse = 1'b1;
          end else begin
            state_nx = S_DELAY;
            cnt_nx   = delay_q;
          end
        end
      end
      S_DELAY: begin
        if (cnt <= CNT_ONE) enter_pulse = 1'b1;
        else                cnt_nx      = cnt - CNT_ONE;
      end
      S_PULSE: begin
        if (cnt <= CNT_ONE) begin
          if (pulse_cnt_q >= repeat_q) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = S_GAP;
            cnt_nx   = gap_q;
          end
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt <= CNT_ONE) enter_pulse = 1'b1;
        else                cnt_nx      = cnt - CNT_ONE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (enter_pulse) begin
      state_nx = S_PULSE;
      cnt_nx   = width_q;
      if (pulse_cnt_q != REP_MAX) pulse_cnt_nx = pulse_cnt_q + REP_ONE;
    end

    // Abort dominates everything, including a same-cycle arm.
    if (bus.abort) begin
      state_nx     = S_IDLE;
      cnt_nx       = cnt;
      pulse_cnt_nx = pulse_cnt_q;
      latch_cfg    = 1'b0;
      done_nx      = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      pulse_cnt_q   <= '0;
      glitch_en_q   <= 1'b0;
      glitch_mode_q <= 8'h00;
      armed_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      pulse_cnt_q   <= pulse_cnt_nx;
      glitch_en_q   <= (state_nx == S_PULSE);
      glitch_mode_q <= (state_nx == S_PULSE) ? mode_q : 8'h00;
      armed_q       <= (state_nx == S_ARMED);
      busy_q        <= (state_nx != S_IDLE);
      done_q        <= done_nx;
    end
  end

  assign bus.glitch_en   = glitch_en_q;
  assign bus.glitch_mode = glitch_mode_q;
  assign bus.armed       = armed_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulse_cnt   = pulse_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_glitch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_glitch_sequencer : directed table-driven bench for glitch_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_glitch_sequencer;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  always #5 clk_in = ~clk_in;

  glitch_sequencer_if #(.CNT_W(16), .REP_W(8)) bus ();

  glitch_sequencer #(.CNT_W(16), .REP_W(8)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [15:0] w;
    logic [15:0] g;
    logic [7:0]  r;
    logic [7:0]  m;
    logic [31:0] en_mask;   // bit i-1 = glitch_en in cycle E+i
    logic [31:0] done_mask;
    logic [7:0]  cnt;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en"},    32'(bus.glitch_en),   32'h0);
    chk({tag, "_mode"},  32'(bus.glitch_mode), 32'h0);
    chk({tag, "_armed"}, 32'(bus.armed),       32'h0);
    chk({tag, "_busy"},  32'(bus.busy),        32'h0);
    chk({tag, "_done"},  32'(bus.done),        32'h0);
    chk({tag, "_pcnt"},  32'(bus.pulse_cnt),   32'h0);
  endtask

  // Arms with the vector's config, then raises trigger; returns at edge E.
  task automatic arm_and_trigger(input vec_t v, output logic armed_a);
    bus.cfg_delay  = v.d;
    bus.cfg_width  = v.w;
    bus.cfg_gap    = v.g;
    bus.cfg_repeat = v.r;
    bus.cfg_mode   = v.m;
    bus.arm        = 1'b1;
    step();
    bus.arm = 1'b0;
    armed_a = bus.armed;
    bus.trigger = 1'b1;
    step();   // stage 1 captures
    step();   // stage 2 captures: edge E
  endtask

  task automatic run_seq(input vec_t v, output logic [31:0] enm, output logic [31:0] dnm,
                         output logic [7:0] cnt_a, output logic mode_ok, output logic armed_a,
                         output logic busy_a);
    arm_and_trigger(v, armed_a);
    enm = '0;
    dnm = '0;
    mode_ok = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      enm[i-1] = bus.glitch_en;
      dnm[i-1] = bus.done;
      if (bus.glitch_mode !== (bus.glitch_en ? v.m : 8'h00)) mode_ok = 1'b0;
    end
    cnt_a  = bus.pulse_cnt;
    busy_a = bus.busy;
    bus.trigger = 1'b0;
    repeat (3) step();
  endtask

  vec_t vecs[4];

  initial begin
    logic [31:0] enm, dnm;
    logic [7:0]  cnt_a;
    logic        mode_ok, armed_a, busy_a, seen;
    vec_t        v;

    vecs[0] = '{"basic", 16'd3, 16'd2, 16'd1, 8'd1, 8'h08, 32'h0000_0018, 32'h0000_0020, 8'd1};
    vecs[1] = '{"zero",  16'd0, 16'd0, 16'd0, 8'd0, 8'h02, 32'h0000_0001, 32'h0000_0002, 8'd1};
    vecs[2] = '{"burst", 16'd1, 16'd3, 16'd2, 8'd3, 8'h04, 32'h0000_39CE, 32'h0000_4000, 8'd3};
    vecs[3] = '{"gap0",  16'd2, 16'd1, 16'd0, 8'd2, 8'h01, 32'h0000_0014, 32'h0000_0020, 8'd2};

    bus.arm = 1'b0; bus.abort = 1'b0; bus.trigger = 1'b0;
    bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0;
    bus.cfg_repeat = '0; bus.cfg_mode = '0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) step();

    for (int k = 0; k < 4; k++) begin
      run_seq(vecs[k], enm, dnm, cnt_a, mode_ok, armed_a, busy_a);
      chk({vecs[k].name, "_armed"},   32'(armed_a), 32'h1);
      chk({vecs[k].name, "_en"},      enm, vecs[k].en_mask);
      chk({vecs[k].name, "_done"},    dnm, vecs[k].done_mask);
      chk({vecs[k].name, "_mode"},    32'(mode_ok), 32'h1);
      chk({vecs[k].name, "_pcnt"},    32'(cnt_a), 32'(vecs[k].cnt));
      chk({vecs[k].name, "_busy_end"}, 32'(busy_a), 32'h0);
    end

    // Trigger edge while IDLE must not produce a pulse.
    bus.trigger = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | bus.glitch_en | bus.busy;
    end
    chk("idle_trigger", 32'(seen), 32'h0);
    bus.trigger = 1'b0;
    repeat (3) step();

    // Abort in the fifth pulse cycle of a long pulse.
    v = '{"abort", 16'd0, 16'd10, 16'd1, 8'd1, 8'h08, 32'h0, 32'h0, 8'd1};
    arm_and_trigger(v, armed_a);
    repeat (4) step();
    chk("abort_pre_en", 32'(bus.glitch_en), 32'h1);
    bus.abort = 1'b1;
    step();
    chk("abort_en",   32'(bus.glitch_en),   32'h0);
    chk("abort_mode", 32'(bus.glitch_mode), 32'h0);
    chk("abort_busy", 32'(bus.busy),        32'h0);
    bus.abort = 1'b0;
    bus.trigger = 1'b0;
    seen = bus.done;
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | bus.done | bus.glitch_en | bus.armed;
    end
    chk("abort_no_done", 32'(seen), 32'h0);
    chk("abort_pcnt",    32'(bus.pulse_cnt), 32'h1);

    // Re-arm during DELAY with a different delay must be ignored.
    v = '{"rearm", 16'd5, 16'd1, 16'd1, 8'd1, 8'h08, 32'h0, 32'h0, 8'd1};
    arm_and_trigger(v, armed_a);
    enm = '0; dnm = '0;
    for (int i = 1; i <= 16; i++) begin
      step();
      enm[i-1] = bus.glitch_en;
      dnm[i-1] = bus.done;
      if (i == 2) begin
        bus.cfg_delay = 16'd1;
        bus.arm = 1'b1;
      end else begin
        bus.arm = 1'b0;
      end
    end
    chk("rearm_en",   enm, 32'h0000_0020);
    chk("rearm_done", dnm, 32'h0000_0040);
    chk("rearm_pcnt", 32'(bus.pulse_cnt), 32'h1);
    bus.trigger = 1'b0;
    repeat (3) step();

    // arm and abort together from IDLE: abort wins.
    bus.arm = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    chk("armabort_armed", 32'(bus.armed), 32'h0);
    chk("armabort_busy",  32'(bus.busy),  32'h0);
    step();
    chk("armabort_armed2", 32'(bus.armed), 32'h0);

    // Asynchronous reset during the first gap of a burst.
    arm_and_trigger(vecs[2], armed_a);
    repeat (5) step();
    chk("rstgap_busy_pre", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstgap");
    bus.trigger = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    run_seq(vecs[0], enm, dnm, cnt_a, mode_ok, armed_a, busy_a);
    chk("post_rst_en",   enm, vecs[0].en_mask);
    chk("post_rst_done", dnm, vecs[0].done_mask);
    chk("post_rst_pcnt", 32'(cnt_a), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
